// File: rtl/demux_1x4_dispatch.sv
// -----------------------------------------------------------------------------
// demux_1x4_dispatch
//
// Sequencer for a shared 1-to-4 demultiplexer. Accepts one word at a time on a
// valid/ready input, holds it on a broadcast data bus and raises the one-hot
// valid of exactly one sink until that sink accepts it. The destination is
// either the per-word tag (directed mode) or a rotating pointer (round-robin
// mode). A word stuck behind a stalled sink for TIMEOUT cycles is dropped,
// pulsing err_drop and bumping a saturating drop counter.
//
// Parameters
//   DW       data word width
//   TIMEOUT  HOLD cycles without sink ready before a drop; 0 disables dropping
//            (legal range 0..255)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_data    word to dispatch
//   in_dest    destination sink index, used in directed mode only
//   in_valid   upstream word valid
//   in_ready   high while the controller can accept a word (IDLE)
//   mode       0 = directed by in_dest, 1 = round-robin
//   out_data   held word, broadcast to all sinks
//   out_valid  one-hot valid to the selected sink
//   out_ready  per-sink ready
//   sel        demux select, index of the held word's target
//   err_drop   one-cycle pulse when a word is dropped on timeout
//   drop_cnt   saturating count of dropped words
// -----------------------------------------------------------------------------
module demux_1x4_dispatch #(
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic [1:0]    in_dest,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          mode,
   output logic [DW-1:0] out_data,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [1:0]    sel,
   output logic          err_drop,
   output logic [7:0]    drop_cnt
);

   typedef enum logic [0:0] {
      StIdle,
      StHold
   } state_e;

   // Timer value on the last HOLD cycle before a drop. Only meaningful when
   // TIMEOUT is non-zero; the zero case is guarded separately.
   localparam int unsigned TimeoutLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [7:0]  TimerLast   = 8'(TimeoutLast);
   localparam logic        DropEnable  = (TIMEOUT != 0);

   state_e        state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    valid_q, valid_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [7:0]    timer_q, timer_d;
   logic          err_drop_q, err_drop_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   logic [1:0]    target;
   logic          sink_ready;
   logic          timed_out;

   // Destination of a word captured this cycle.
   assign target     = mode ? rr_ptr_q : in_dest;
   assign sink_ready = out_ready[sel_q];
   assign timed_out  = DropEnable && (timer_q == TimerLast);

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      sel_d      = sel_q;
      valid_d    = valid_q;
      rr_ptr_d   = rr_ptr_q;
      timer_d    = timer_q;
      err_drop_d = 1'b0;
      drop_cnt_d = drop_cnt_q;

      unique case (state_q)
         StIdle: begin
            valid_d = 4'b0000;
            if (in_valid) begin
               data_d  = in_data;
               sel_d   = target;
               // One-hot valid is registered here so out_valid has no
               // combinational path from the inputs.
               valid_d = 4'(1) << target;
               timer_d = 8'd0;
               if (mode) begin
                  rr_ptr_d = rr_ptr_q + 2'd1;
               end
               state_d = StHold;
            end
         end

         StHold: begin
            // Transfer takes priority over a coincident timeout.
            if (sink_ready) begin
               valid_d = 4'b0000;
               state_d = StIdle;
            end else if (timed_out) begin
               valid_d    = 4'b0000;
               err_drop_d = 1'b1;
               if (drop_cnt_q != 8'hFF) begin
                  drop_cnt_d = drop_cnt_q + 8'd1;
               end
               state_d = StIdle;
            end else if (timer_q != 8'hFF) begin
               timer_d = timer_q + 8'd1;
            end
         end

         default: begin
            valid_d = 4'b0000;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         data_q     <= '0;
         sel_q      <= 2'd0;
         valid_q    <= 4'b0000;
         rr_ptr_q   <= 2'd0;
         timer_q    <= 8'd0;
         err_drop_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         sel_q      <= sel_d;
         valid_q    <= valid_d;
         rr_ptr_q   <= rr_ptr_d;
         timer_q    <= timer_d;
         err_drop_q <= err_drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign sel       = sel_q;
   assign err_drop  = err_drop_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1x4_dispatch.sv
module tb_demux_1x4_dispatch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic [1:0] in_dest = 2'd0;
   logic       in_valid = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] out_ready = 4'b0000;

   // Instance A: TIMEOUT=16
   logic       a_in_ready, a_err_drop;
   logic [7:0] a_out_data, a_drop_cnt;
   logic [3:0] a_out_valid;
   logic [1:0] a_sel;

   // Instance B: TIMEOUT=4, same stimulus
   logic       b_in_ready, b_err_drop;
   logic [7:0] b_out_data, b_drop_cnt;
   logic [3:0] b_out_valid;
   logic [1:0] b_sel;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   demux_1x4_dispatch #(.DW(8), .TIMEOUT(16)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_dest  (in_dest),
      .in_valid (in_valid),
      .in_ready (a_in_ready),
      .mode     (mode),
      .out_data (a_out_data),
      .out_valid(a_out_valid),
      .out_ready(out_ready),
      .sel      (a_sel),
      .err_drop (a_err_drop),
      .drop_cnt (a_drop_cnt)
   );

   demux_1x4_dispatch #(.DW(8), .TIMEOUT(4)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_dest  (in_dest),
      .in_valid (in_valid),
      .in_ready (b_in_ready),
      .mode     (mode),
      .out_data (b_out_data),
      .out_valid(b_out_valid),
      .out_ready(out_ready),
      .sel      (b_sel),
      .err_drop (b_err_drop),
      .drop_cnt (b_drop_cnt)
   );

   typedef struct {
      logic       mode;
      logic [1:0] dest;
      logic [7:0] data;
      logic [3:0] ready;
      logic [1:0] exp_sel;
      logic [3:0] exp_valid;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      rst = 1'b0;
   endtask

   // One-cycle input handshake; the DUT is in IDLE beforehand.
   task automatic offer(input logic m, input logic [1:0] d, input logic [7:0] dat,
                        input logic [3:0] rdy);
      mode      = m;
      in_dest   = d;
      in_data   = dat;
      out_ready = rdy;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      // Directed transfers and round-robin rotation (rr_ptr starts at 0).
      vecs[0] = '{1'b0, 2'd2, 8'hA5, 4'b0100, 2'd2, 4'b0100};
      vecs[1] = '{1'b0, 2'd0, 8'h3C, 4'b0001, 2'd0, 4'b0001};
      vecs[2] = '{1'b1, 2'd3, 8'h11, 4'b1111, 2'd0, 4'b0001};
      vecs[3] = '{1'b1, 2'd3, 8'h12, 4'b1111, 2'd1, 4'b0010};
      vecs[4] = '{1'b1, 2'd3, 8'h13, 4'b1111, 2'd2, 4'b0100};
      vecs[5] = '{1'b1, 2'd3, 8'h14, 4'b1111, 2'd3, 4'b1000};
      vecs[6] = '{1'b1, 2'd3, 8'h15, 4'b1111, 2'd0, 4'b0001};
      vecs[7] = '{1'b0, 2'd2, 8'h77, 4'b1111, 2'd2, 4'b0100};
      vecs[8] = '{1'b1, 2'd0, 8'h88, 4'b1111, 2'd1, 4'b0010};

      // Reset state
      do_reset(2);
      chk("rst_out_valid", 32'(a_out_valid), 32'h0);
      chk("rst_sel",       32'(a_sel),       32'h0);
      chk("rst_in_ready",  32'(a_in_ready),  32'h1);
      chk("rst_drop_cnt",  32'(a_drop_cnt),  32'h0);
      chk("rst_err_drop",  32'(a_err_drop),  32'h0);
      chk("rst_out_data",  32'(a_out_data),  32'h0);

      // Table-driven single-hold-cycle transfers
      foreach (vecs[i]) begin
         offer(vecs[i].mode, vecs[i].dest, vecs[i].data, vecs[i].ready);
         chk($sformatf("v%0d_in_ready_hold", i), 32'(a_in_ready),  32'h0);
         chk($sformatf("v%0d_out_valid", i),     32'(a_out_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("v%0d_sel", i),           32'(a_sel),       32'(vecs[i].exp_sel));
         chk($sformatf("v%0d_out_data", i),      32'(a_out_data),  32'(vecs[i].data));
         tick();
         chk($sformatf("v%0d_in_ready_idle", i), 32'(a_in_ready),  32'h1);
         chk($sformatf("v%0d_valid_idle", i),    32'(a_out_valid), 32'h0);
         chk($sformatf("v%0d_err_drop", i),      32'(a_err_drop),  32'h0);
      end

      // Stall for 5 HOLD cycles (TIMEOUT=16); mode/in_dest wiggle must not matter,
      // and readiness of non-selected sinks is ignored.
      offer(1'b0, 2'd1, 8'h5A, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_valid", i),    32'(a_out_valid), 32'b0010);
         chk($sformatf("stall%0d_data", i),     32'(a_out_data),  32'h5A);
         chk($sformatf("stall%0d_sel", i),      32'(a_sel),       32'h1);
         chk($sformatf("stall%0d_in_ready", i), 32'(a_in_ready),  32'h0);
         chk($sformatf("stall%0d_err", i),      32'(a_err_drop),  32'h0);
         mode      = 1'(i);
         in_dest   = 2'(i + 2);
         out_ready = (i < 2) ? 4'b0000 : 4'b1101;
         tick();
      end
      chk("stall5_valid", 32'(a_out_valid), 32'b0010);
      chk("stall5_data",  32'(a_out_data),  32'h5A);
      out_ready = 4'b0010;
      tick();
      chk("stall_done_in_ready", 32'(a_in_ready),  32'h1);
      chk("stall_done_valid",    32'(a_out_valid), 32'h0);
      chk("stall_done_err",      32'(a_err_drop),  32'h0);
      chk("stall_done_cnt",      32'(a_drop_cnt),  32'h0);

      // Timeout drop on instance B (TIMEOUT=4)
      do_reset(2);
      offer(1'b0, 2'd3, 8'hC3, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_hold%0d_in_ready", i), 32'(b_in_ready),  32'h0);
         chk($sformatf("to_hold%0d_valid", i),    32'(b_out_valid), 32'b1000);
         chk($sformatf("to_hold%0d_err", i),      32'(b_err_drop),  32'h0);
         tick();
      end
      chk("to_err_pulse", 32'(b_err_drop),  32'h1);
      chk("to_cnt",       32'(b_drop_cnt),  32'h1);
      chk("to_in_ready",  32'(b_in_ready),  32'h1);
      chk("to_valid",     32'(b_out_valid), 32'h0);
      tick();
      chk("to_err_clear", 32'(b_err_drop),  32'h0);
      chk("to_cnt_hold",  32'(b_drop_cnt),  32'h1);

      // Ready coincides with the timeout edge: transfer wins
      offer(1'b0, 2'd3, 8'hD4, 4'b0000);
      for (int i = 0; i < 3; i++) tick();
      chk("race_still_hold", 32'(b_in_ready), 32'h0);
      out_ready = 4'b1000;
      tick();
      chk("race_err",      32'(b_err_drop), 32'h0);
      chk("race_cnt",      32'(b_drop_cnt), 32'h1);
      chk("race_in_ready", 32'(b_in_ready), 32'h1);
      tick();
      chk("race_err_late", 32'(b_err_drop), 32'h0);

      // Reset during HOLD discards the word and clears rr_ptr
      do_reset(1);
      offer(1'b1, 2'd0, 8'h01, 4'b1111);
      tick();
      offer(1'b0, 2'd3, 8'h99, 4'b0000);
      chk("rh_sel",   32'(a_sel),       32'h3);
      chk("rh_valid", 32'(a_out_valid), 32'b1000);
      do_reset(1);
      chk("rh_valid_after",    32'(a_out_valid), 32'h0);
      chk("rh_in_ready_after", 32'(a_in_ready),  32'h1);
      chk("rh_cnt_after",      32'(a_drop_cnt),  32'h0);
      chk("rh_err_after",      32'(a_err_drop),  32'h0);
      offer(1'b1, 2'd2, 8'h42, 4'b1111);
      chk("rh_rr_restart_sel", 32'(a_sel), 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
